// File: rtl/rns_pkg.sv
// rns_pkg: constants and types shared by the {5,7,11,13} RNS reverse converter.
//   Moduli M5..M13 and their product M_TOTAL, the MRC inverse constants K1..K6,
//   the radix weights W5/W35/W385, the decoder FSM state type and the modulus select type.
package rns_pkg;
    localparam int M5 = 5, M7 = 7, M11 = 11, M13 = 13, M_TOTAL = 5005;
    localparam logic [3:0] K1 = 4'd3, K2 = 4'd9, K3 = 4'd8, K4 = 4'd8, K5 = 4'd2, K6 = 4'd6;
    localparam logic [12:0] W5 = 13'd5, W35 = 13'd35, W385 = 13'd385;
    typedef enum logic [1:0] {IDLE, CALC, ACC, HOLD} state_t;
    typedef enum logic [1:0] {SEL7, SEL11, SEL13} msel_t;
endpackage

// File: rtl/rns_modsub_mul.sv
// rns_modsub_mul: combinational y = (((a-b) mod m) * k) mod m, m chosen by sel from {7,11,13}.
//   a, b : operands (in range for m when the tuple is legal)
//   k    : constant multiplier
//   sel  : modulus select
//   y    : fully reduced result in [0,m-1]
module rns_modsub_mul import rns_pkg::*; (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] k,
    input  msel_t      sel,
    output logic [3:0] y
);
    logic [4:0] m, d;
    logic [8:0] p;
    always_comb begin
        m = sel == SEL7 ? 5'(M7) : sel == SEL11 ? 5'(M11) : 5'(M13);
        d = a >= b ? {1'b0, a} - {1'b0, b} : {1'b0, a} - {1'b0, b} + m;
        p = 9'(d) * 9'(k);
        // Constant-modulus reductions muxed afterwards instead of dividing by a variable modulus
        y = sel == SEL7 ? 4'(p % 9'(M7)) : sel == SEL11 ? 4'(p % 9'(M11)) : 4'(p % 9'(M13));
    end
endmodule

// File: rtl/rns_mrc_decoder.sv
// rns_mrc_decoder: mixed-radix reverse converter for the {5,7,11,13} RNS, X in [0,5004].
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_ready : input handshake for residues r5, r7, r11, r13
//   out_valid/out_ready : output handshake for x (OUT_W bits, zero-filled) and err
//   Macro RNS_DEC_RANGE_CHK_EN: flags out-of-range residues with err=1 and forces x=0;
//   when undefined err is always 0.
module rns_mrc_decoder import rns_pkg::*; #(
    parameter int OUT_W = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       r5,
    input  logic [2:0]       r7,
    input  logic [3:0]       r11,
    input  logic [3:0]       r13,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] x,
    output logic             err
);
    state_t     state;
    logic [2:0] step;
    logic [3:0] c5, c7, c11, c13, v2, t3, t4, v3, v4, a, b, k, y;
    msel_t      sel;
    logic [12:0] sum;
`ifdef RNS_DEC_RANGE_CHK_EN
    logic bad;
`else
    localparam logic bad = 1'b0;
`endif

    rns_modsub_mul u_msm (.a(a), .b(b), .k(k), .sel(sel), .y(y));

    // Operand routing for the single shared modular unit, one MRC step per cycle
    always_comb begin
        a   = step == 3'd1 ? c7 : step == 3'd2 ? c11 : step == 3'd3 ? c13 : step == 3'd4 ? t3 : t4;
        b   = step <= 3'd3 ? c5 : step == 3'd6 ? v3 : v2;
        k   = step == 3'd1 ? K1 : step == 3'd2 ? K2 : step == 3'd3 ? K3 :
              step == 3'd4 ? K4 : step == 3'd5 ? K5 : K6;
        sel = step == 3'd1 ? SEL7 : (step == 3'd2 || step == 3'd4) ? SEL11 : SEL13;
        sum = 13'(c5) + W5 * 13'(v2) + W35 * 13'(v3) + W385 * 13'(v4);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            step      <= 3'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            x         <= '0;
            err       <= 1'b0;
            c5        <= '0;
            c7        <= '0;
            c11       <= '0;
            c13       <= '0;
            v2        <= '0;
            t3        <= '0;
            t4        <= '0;
            v3        <= '0;
            v4        <= '0;
`ifdef RNS_DEC_RANGE_CHK_EN
            bad       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    c5       <= {1'b0, r5};
                    c7       <= {1'b0, r7};
                    c11      <= r11;
                    c13      <= r13;
`ifdef RNS_DEC_RANGE_CHK_EN
                    bad      <= (r5 >= 3'(M5)) | (r7 >= 3'(M7)) | (r11 >= 4'(M11)) | (r13 >= 4'(M13));
`endif
                    step     <= 3'd1;
                    in_ready <= 1'b0;
                    state    <= CALC;
                end
                CALC: begin
                    case (step)
                        3'd1:    v2 <= y;
                        3'd2:    t3 <= y;
                        3'd3:    t4 <= y;
                        3'd4:    v3 <= y;
                        3'd5:    t4 <= y;
                        default: v4 <= y;
                    endcase
                    step  <= step + 3'd1;
                    state <= step == 3'd6 ? ACC : CALC;
                end
                ACC: begin
                    x         <= bad ? '0 : OUT_W'(sum);
                    err       <= bad;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                default: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rns_mrc_decoder.sv
// tb_rns_mrc_decoder: directed and random checks of rns_mrc_decoder against a CRT search model.
module tb_rns_mrc_decoder;
    localparam int OUT_W = 13;
    logic             clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    logic [2:0]       r5 = 0, r7 = 0;
    logic [3:0]       r11 = 0, r13 = 0;
    logic             in_ready, out_valid, err;
    logic [OUT_W-1:0] x;
    int total = 0, bad = 0;

    rns_mrc_decoder #(.OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .r5(r5), .r7(r7), .r11(r11), .r13(r13),
        .out_valid(out_valid), .out_ready(out_ready), .x(x), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: the unique X in [0,5004] matching all four residues
    function automatic int ref_x(input int a, input int b, input int c, input int d);
        for (int v = 0; v < 5005; v++)
            if (v % 5 == a && v % 7 == b && v % 11 == c && v % 13 == d) return v;
        return -1;
    endfunction

    task automatic issue(input int a, input int b, input int c, input int d);
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1; r5 = 3'(a); r7 = 3'(b); r11 = 4'(c); r13 = 4'(d);
        @(posedge clk); #1;
        in_valid = 0;
        r5 = 3'($urandom); r7 = 3'($urandom); r11 = 4'($urandom); r13 = 4'($urandom);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        chk("ov_cleared", out_valid, 0);
        chk("in_ready_back", in_ready, 1);
    endtask

    task automatic decode(input string tag, input int a, input int b, input int c, input int d);
        int lat;
        issue(a, b, c, d);
        wait_out(lat);
        chk({tag, "_lat"}, lat, 7);
        chk({tag, "_x"}, x, ref_x(a, b, c, d));
        chk({tag, "_err"}, err, 0);
        release_out();
    endtask

    initial begin
        int lat, v;
        logic [OUT_W-1:0] xh;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_x", x, 0);
        chk("rst_err", err, 0);
        @(negedge clk); rst = 0;

        decode("zero", 0, 0, 0, 0);
        decode("d1234", 4, 2, 2, 12);
        chk("d1234_ref", ref_x(4, 2, 2, 12), 1234);
        decode("max", 4, 6, 10, 12);
        decode("one", 1, 1, 1, 1);

        // Backpressure with a competing tuple offered while busy
        issue(0, 0, 0, 0);
        wait_out(lat);
        chk("bp_lat", lat, 7);
        xh = x;
        chk("bp_x", xh, 0);
        @(negedge clk);
        in_valid = 1; r5 = 3; r7 = 3; r11 = 3; r13 = 3;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_x", x, 32'(xh));
            chk("bp_hold_ov", out_valid, 1);
            chk("bp_hold_ir", in_ready, 0);
        end
        @(negedge clk);
        in_valid = 0;
        release_out();
        decode("after_bp", 3, 4, 5, 6);

        // Reset while step 3 is pending
        issue(4, 2, 2, 12);
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst = 1; #1;
        chk("midrst_ov", out_valid, 0);
        chk("midrst_ir", in_ready, 1);
        @(negedge clk); rst = 0;
        decode("post_rst", 4, 2, 2, 12);

        // Out-of-range residue
        issue(5, 0, 0, 0);
        wait_out(lat);
        chk("range_lat", lat, 7);
`ifdef RNS_DEC_RANGE_CHK_EN
        chk("range_err", err, 1);
        chk("range_x", x, 0);
`else
        chk("range_err", err, 0);
`endif
        release_out();

        // Random values with random output backpressure
        for (int n = 0; n < 20; n++) begin
            v = $urandom_range(0, 5004);
            issue(v % 5, v % 7, v % 11, v % 13);
            wait_out(lat);
            chk("rnd_lat", lat, 7);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            chk("rnd_x", x, v);
            chk("rnd_err", err, 0);
            release_out();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
